// File: rtl/reaction_stats.sv
// Reaction-time statistics: last/min/max/sum/count with a restoring divider for the average.
// Optional AVG_ROUND_EN: round-half-up average instead of truncation.
module reaction_stats #(
  parameter int unsigned DATA_W     = 10,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned MAX_TRIALS = 15,
  parameter int unsigned SAT_VAL    = 999
) (
  input  logic              clk_50M,
  input  logic              clear,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] result,
  input  logic              foul,
  input  logic              stats_clr,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] disp_value,
  output logic              disp_blank,
  output logic [CNT_W-1:0]  trial_cnt,
  output logic              busy,
  output logic              full,
  output logic              overrun
);

  localparam int unsigned SUM_W   = DATA_W + CNT_W;
  localparam int unsigned DIV_CYC = DATA_W + CNT_W;
  localparam int unsigned STEP_W  = $clog2(DIV_CYC + 1);
`ifdef AVG_ROUND_EN
  localparam int unsigned DVD_W   = SUM_W + 1;
`else
  localparam int unsigned DVD_W   = SUM_W;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIVIDE} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_pend;
  logic                r_pend_full;
  logic [DATA_W-1:0]   r_last;
  logic [DATA_W-1:0]   r_min;
  logic [DATA_W-1:0]   r_max;
  logic [DATA_W-1:0]   r_avg;
  logic [SUM_W-1:0]    r_sum;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_div;
  logic [CNT_W-1:0]    r_rem;
  logic [SUM_W-1:0]    r_quo;
  logic [STEP_W-1:0]   r_step;
  logic                r_full;
  logic                r_busy;
  logic                r_overrun;
  logic [DATA_W-1:0]   r_disp_value;
  logic                r_disp_blank;

  logic [DATA_W-1:0]   w_res_sat;
  logic                w_accept;
  logic [SUM_W-1:0]    w_sum_new;
  logic [CNT_W-1:0]    w_cnt_new;
  logic [DVD_W-1:0]    w_dividend;
  logic [CNT_W:0]      w_trial;
  logic                w_ge;
  logic [CNT_W-1:0]    w_rem_next;
  logic [SUM_W-1:0]    w_quo_next;
  logic [DATA_W-1:0]   w_sel_val;

  assign w_res_sat = (result > DATA_W'(SAT_VAL)) ? DATA_W'(SAT_VAL) : result;
  assign w_accept  = result_valid & ~foul & ~r_full;
  assign w_sum_new = r_sum + SUM_W'(r_pend);
  assign w_cnt_new = r_count + CNT_W'(1);
`ifdef AVG_ROUND_EN
  assign w_dividend = DVD_W'(w_sum_new) + DVD_W'(w_cnt_new >> 1);
`else
  assign w_dividend = w_sum_new;
`endif

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign w_trial    = {r_rem, r_quo[SUM_W-1]};
  assign w_ge       = (w_trial >= {1'b0, r_div});
  assign w_rem_next = w_ge ? CNT_W'(w_trial - {1'b0, r_div}) : w_trial[CNT_W-1:0];
  assign w_quo_next = {r_quo[SUM_W-2:0], w_ge};

  always_comb begin
    w_sel_val = r_last;
    case (sel)
      2'b01:   w_sel_val = r_min;
      2'b10:   w_sel_val = r_max;
      2'b11:   w_sel_val = r_avg;
      default: w_sel_val = r_last;
    endcase
  end

  always_ff @(posedge clk_50M or negedge clear) begin
    if (!clear) begin
      r_state      <= S_IDLE;
      r_pend       <= '0;
      r_pend_full  <= 1'b0;
      r_last       <= '0;
      r_min        <= '1;
      r_max        <= '0;
      r_avg        <= '0;
      r_sum        <= '0;
      r_count      <= '0;
      r_div        <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_step       <= '0;
      r_full       <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_disp_value <= '0;
      r_disp_blank <= 1'b1;
    end else if (stats_clr) begin
      r_state      <= S_IDLE;
      r_pend       <= '0;
      r_pend_full  <= 1'b0;
      r_last       <= '0;
      r_min        <= '1;
      r_max        <= '0;
      r_avg        <= '0;
      r_sum        <= '0;
      r_count      <= '0;
      r_div        <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_step       <= '0;
      r_full       <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_disp_value <= '0;
      r_disp_blank <= 1'b1;
    end else begin
      r_disp_value <= (r_count == '0) ? '0 : w_sel_val;
      r_disp_blank <= (r_count == '0);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pend      <= w_res_sat;
            r_pend_full <= 1'b1;
            r_state     <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          // Pending is consumed here, so a same-cycle arrival can take its slot.
          r_pend_full <= w_accept;
          if (w_accept) r_pend <= w_res_sat;
          if (r_full) begin
            r_state <= S_IDLE;
          end else begin
            r_last  <= r_pend;
            if (r_pend < r_min) r_min <= r_pend;
            if (r_pend > r_max) r_max <= r_pend;
            r_sum   <= w_sum_new;
            r_count <= w_cnt_new;
            r_full  <= (w_cnt_new == CNT_W'(MAX_TRIALS));
            r_div   <= w_cnt_new;
`ifdef AVG_ROUND_EN
            r_rem   <= CNT_W'(w_dividend[SUM_W]);
`else
            r_rem   <= '0;
`endif
            r_quo   <= w_dividend[SUM_W-1:0];
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_state <= S_DIVIDE;
          end
        end
        S_DIVIDE: begin
          r_rem  <= w_rem_next;
          r_quo  <= w_quo_next;
          r_step <= r_step + STEP_W'(1);
          if (w_accept) begin
            if (!r_pend_full) begin
              r_pend      <= w_res_sat;
              r_pend_full <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end
          if (r_step == STEP_W'(DIV_CYC - 1)) begin
            r_avg   <= w_quo_next[DATA_W-1:0];
            r_busy  <= 1'b0;
            r_state <= (r_pend_full || w_accept) ? S_ACCUM : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign disp_value = r_disp_value;
  assign disp_blank = r_disp_blank;
  assign trial_cnt  = r_count;
  assign busy       = r_busy;
  assign full       = r_full;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_reaction_stats.sv
// Directed self-checking bench for reaction_stats; inputs change on the falling edge, outputs read there too.
module tb_reaction_stats;

  logic       clk_50M = 1'b0;
  logic       clear;
  logic       result_valid;
  logic [9:0] result;
  logic       foul;
  logic       stats_clr;
  logic [1:0] sel;
  logic [9:0] disp_value;
  logic       disp_blank;
  logic [3:0] trial_cnt;
  logic       busy;
  logic       full;
  logic       overrun;

  int tests = 0;
  int fails = 0;

`ifdef AVG_ROUND_EN
  localparam logic [9:0] AVG_BASIC = 10'd217;
`else
  localparam logic [9:0] AVG_BASIC = 10'd216;
`endif

  reaction_stats dut (
    .clk_50M(clk_50M), .clear(clear), .result_valid(result_valid), .result(result),
    .foul(foul), .stats_clr(stats_clr), .sel(sel), .disp_value(disp_value),
    .disp_blank(disp_blank), .trial_cnt(trial_cnt), .busy(busy), .full(full), .overrun(overrun)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic send(input logic [9:0] v, input logic f);
    result = v; foul = f; result_valid = 1'b1;
    @(negedge clk_50M);
    result_valid = 1'b0; foul = 1'b0; result = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic read_sel(input logic [1:0] s, output logic [9:0] v);
    sel = s;
    @(negedge clk_50M);
    v = disp_value;
  endtask

  task automatic pulse_stats_clr();
    stats_clr = 1'b1;
    @(negedge clk_50M);
    stats_clr = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b0;
    idle(3);
    tests++; if (disp_value !== 10'd0) begin fails++; $display("FAIL reset_value got %0d want 0", disp_value); end
    tests++; if (disp_blank !== 1'b1) begin fails++; $display("FAIL reset_blank got %b want 1", disp_blank); end
    tests++; if ({busy, full, overrun} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {busy, full, overrun}); end
    clear = 1'b1;
    idle(2);
    tests++; if (trial_cnt !== 4'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", trial_cnt); end
    tests++; if (disp_blank !== 1'b1) begin fails++; $display("FAIL reset_blank_after got %b want 1", disp_blank); end
  endtask

  task automatic test_basic();
    logic [9:0] v;
    send(10'd200, 1'b0); idle(25);
    send(10'd150, 1'b0); idle(25);
    send(10'd300, 1'b0); idle(25);
    read_sel(2'b00, v);
    tests++; if (v !== 10'd300) begin fails++; $display("FAIL basic_last got %0d want 300", v); end
    read_sel(2'b01, v);
    tests++; if (v !== 10'd150) begin fails++; $display("FAIL basic_min got %0d want 150", v); end
    read_sel(2'b10, v);
    tests++; if (v !== 10'd300) begin fails++; $display("FAIL basic_max got %0d want 300", v); end
    read_sel(2'b11, v);
    tests++; if (v !== AVG_BASIC) begin fails++; $display("FAIL basic_avg got %0d want %0d", v, AVG_BASIC); end
    tests++; if (trial_cnt !== 4'd3) begin fails++; $display("FAIL basic_cnt got %0d want 3", trial_cnt); end
    tests++; if (disp_blank !== 1'b0) begin fails++; $display("FAIL basic_blank got %b want 0", disp_blank); end
  endtask

  task automatic test_foul_clamp();
    logic [9:0] v;
    send(10'd0, 1'b1); idle(25);
    tests++; if (trial_cnt !== 4'd3) begin fails++; $display("FAIL foul_cnt got %0d want 3", trial_cnt); end
    read_sel(2'b01, v);
    tests++; if (v !== 10'd150) begin fails++; $display("FAIL foul_min got %0d want 150", v); end
    read_sel(2'b00, v);
    tests++; if (v !== 10'd300) begin fails++; $display("FAIL foul_last got %0d want 300", v); end
    send(10'd1023, 1'b0); idle(25);
    read_sel(2'b00, v);
    tests++; if (v !== 10'd999) begin fails++; $display("FAIL clamp_last got %0d want 999", v); end
    read_sel(2'b10, v);
    tests++; if (v !== 10'd999) begin fails++; $display("FAIL clamp_max got %0d want 999", v); end
    read_sel(2'b11, v);
    tests++; if (v !== 10'd412) begin fails++; $display("FAIL clamp_avg got %0d want 412", v); end
    tests++; if (trial_cnt !== 4'd4) begin fails++; $display("FAIL clamp_cnt got %0d want 4", trial_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] v;
    int runs;
    int lens [4];
    logic prev;
    pulse_stats_clr(); idle(2);
    tests++; if (trial_cnt !== 4'd0) begin fails++; $display("FAIL b2b_clr_cnt got %0d want 0", trial_cnt); end
    runs = 0; prev = 1'b0;
    for (int i = 0; i < 4; i++) lens[i] = 0;
    for (int c = 0; c < 40; c++) begin
      result_valid = (c == 0) || (c == 3) || (c == 5);
      result = (c == 0) ? 10'd100 : (c == 3) ? 10'd120 : (c == 5) ? 10'd140 : 10'd0;
      @(posedge clk_50M); #1;
      if (busy && !prev) runs++;
      if (busy && runs > 0 && runs <= 4) lens[runs-1]++;
      prev = busy;
    end
    result_valid = 1'b0; result = '0;
    @(negedge clk_50M); idle(2);
    tests++; if (runs !== 2) begin fails++; $display("FAIL b2b_busy_runs got %0d want 2", runs); end
    tests++; if (lens[0] !== 14) begin fails++; $display("FAIL b2b_busy_len1 got %0d want 14", lens[0]); end
    tests++; if (lens[1] !== 14) begin fails++; $display("FAIL b2b_busy_len2 got %0d want 14", lens[1]); end
    tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL b2b_overrun got %b want 1", overrun); end
    tests++; if (trial_cnt !== 4'd2) begin fails++; $display("FAIL b2b_cnt got %0d want 2", trial_cnt); end
    read_sel(2'b11, v);
    tests++; if (v !== 10'd110) begin fails++; $display("FAIL b2b_avg got %0d want 110", v); end
    read_sel(2'b00, v);
    tests++; if (v !== 10'd120) begin fails++; $display("FAIL b2b_last got %0d want 120", v); end
    read_sel(2'b01, v);
    tests++; if (v !== 10'd100) begin fails++; $display("FAIL b2b_min got %0d want 100", v); end
  endtask

  task automatic test_full();
    logic [9:0] v;
    pulse_stats_clr();
    for (int i = 0; i < 15; i++) begin
      send(10'd250, 1'b0); idle(20);
      if (i == 13) begin
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL full_early got %b want 0", full); end
      end
    end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL full_flag got %b want 1", full); end
    tests++; if (trial_cnt !== 4'd15) begin fails++; $display("FAIL full_cnt got %0d want 15", trial_cnt); end
    read_sel(2'b11, v);
    tests++; if (v !== 10'd250) begin fails++; $display("FAIL full_avg got %0d want 250", v); end
    send(10'd100, 1'b0); idle(20);
    read_sel(2'b01, v);
    tests++; if (v !== 10'd250) begin fails++; $display("FAIL full_min_after got %0d want 250", v); end
    tests++; if (trial_cnt !== 4'd15) begin fails++; $display("FAIL full_cnt_after got %0d want 15", trial_cnt); end
    tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL full_overrun got %b want 0", overrun); end
  endtask

  task automatic test_clear_mid();
    pulse_stats_clr();
    sel = 2'b00;
    send(10'd500, 1'b0); idle(4);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL clr_mid_busy_pre got %b want 1", busy); end
    pulse_stats_clr();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL clr_mid_busy got %b want 0", busy); end
    tests++; if (disp_blank !== 1'b1) begin fails++; $display("FAIL clr_mid_blank got %b want 1", disp_blank); end
    tests++; if (disp_value !== 10'd0) begin fails++; $display("FAIL clr_mid_value got %0d want 0", disp_value); end
    tests++; if (trial_cnt !== 4'd0) begin fails++; $display("FAIL clr_mid_cnt got %0d want 0", trial_cnt); end
    idle(20);
    send(10'd500, 1'b0); idle(6);
    tests++; if (disp_value !== 10'd500) begin fails++; $display("FAIL async_pre_value got %0d want 500", disp_value); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL async_pre_busy got %b want 1", busy); end
    #5 clear = 1'b0;
    #1;
    tests++; if (disp_value !== 10'd0) begin fails++; $display("FAIL async_value got %0d want 0", disp_value); end
    tests++; if ({disp_blank, busy, full, overrun} !== 4'b1000) begin fails++; $display("FAIL async_flags got %b want 1000", {disp_blank, busy, full, overrun}); end
    tests++; if (trial_cnt !== 4'd0) begin fails++; $display("FAIL async_cnt got %0d want 0", trial_cnt); end
    @(negedge clk_50M);
    clear = 1'b1;
    idle(3);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL async_busy_after got %b want 0", busy); end
  endtask

  task automatic test_simultaneous();
    logic [9:0] v;
    send(10'd300, 1'b0); idle(20);
    result = 10'd200; result_valid = 1'b1; stats_clr = 1'b1;
    @(negedge clk_50M);
    result_valid = 1'b0; stats_clr = 1'b0; result = '0;
    idle(25);
    tests++; if (trial_cnt !== 4'd0) begin fails++; $display("FAIL simul_cnt got %0d want 0", trial_cnt); end
    tests++; if (disp_blank !== 1'b1) begin fails++; $display("FAIL simul_blank got %b want 1", disp_blank); end
    read_sel(2'b00, v);
    tests++; if (v !== 10'd0) begin fails++; $display("FAIL simul_last got %0d want 0", v); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL simul_busy got %b want 0", busy); end
  endtask

  initial begin
    clear = 1'b0; result_valid = 1'b0; result = '0; foul = 1'b0; stats_clr = 1'b0; sel = 2'b00;
    @(negedge clk_50M);
    test_reset();
    test_basic();
    test_foul_clamp();
    test_back_to_back();
    test_full();
    test_clear_mid();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reaction_stats.md
Name: reaction_stats

Overview:
- Sits downstream of the reaction counter and main control FSM.
- On each completed trial, captures the reaction time (0–999 ms) and keeps last, minimum, maximum and running sum / trial count.
- Computes the truncated average with a sequential restoring divider.
- Presents one statistic, chosen by `sel`, to the seven-segment scan stage as a 10-bit value plus a blank flag.

Parameters:
- `DATA_W`, 10, width of the reaction-time value.
- `CNT_W`, 4, width of the trial counter.
- `MAX_TRIALS`, 15, trials accepted before the block reports full; must be ≤ 2^CNT_W−1.
- `SAT_VAL`, 999, clamp value for incoming results.

Ports:
- `clk_50M` in 1: system clock, 50 MHz.
- `clear` in 1: asynchronous active-low reset; all state returns to reset values.
- `result_valid` in 1: single-cycle pulse, trial finished.
- `result` in DATA_W: reaction time in ms, sampled when `result_valid`=1.
- `foul` in 1: qualifies `result_valid`; 1 = stop pressed before LED, trial excluded.
- `stats_clr` in 1: synchronous clear of all statistics, active-high, one cycle.
- `sel` in 2: display select; 00 last, 01 min, 10 max, 11 avg.
- `disp_value` out DATA_W: registered selected statistic.
- `disp_blank` out 1: 1 when no valid trial is stored.
- `trial_cnt` out CNT_W: valid trials accumulated.
- `busy` out 1: divider running.
- `full` out 1: `trial_cnt` == MAX_TRIALS.
- `overrun` out 1: sticky; a result was dropped because the pending buffer was occupied.

Behaviour:
- **Reset values** (`clear`=0, asynchronous): last=0, min=all-ones, max=0, sum=0, count=0, avg=0, pending empty, FSM IDLE, `disp_value`=0, `disp_blank`=1, `busy`=0, `full`=0, `overrun`=0.
- **Input conditioning:** `result` > SAT_VAL is clamped to SAT_VAL before use.
- **Sum width:** DATA_W+CNT_W bits, cannot overflow at MAX_TRIALS.
- **FSM states** IDLE, ACCUM, DIVIDE:
  - IDLE: an accepted result is written to the pending register; go to ACCUM.
  - ACCUM (1 cycle): update last, min (if smaller), max (if larger), sum += r, count += 1; load divider with sum and count; go to DIVIDE.
  - DIVIDE: restoring divider, one quotient bit per cycle, exactly DATA_W+CNT_W cycles (14 at defaults). `busy`=1 from entry to completion. On completion avg ← quotient; go to ACCUM if pending is full, else IDLE.
- **Accept rule:** `result_valid`=1 and `foul`=0 and `full`=0.
  - Foul results are ignored.
  - Results arriving while full are ignored; `overrun` is not set.
- **Arrival during DIVIDE:** an accepted result goes into the one-entry pending register if it is empty. If pending is already full, the new result is dropped and `overrun` is set.
- **Average:** floor(sum/count). avg holds its old value until the divide completes, so `disp_value` for sel=11 updates on the cycle after completion.
- **Output register:** `disp_value` is registered from the `sel` mux, so latency is 1 cycle after `sel` changes or after the selected statistic changes.
- **Blanking:** `disp_blank` = (count==0). When blank, `disp_value`=0 for all `sel`.
- **`stats_clr`:** restores all reset values, including aborting a divide and emptying pending. It takes priority over a simultaneous `result_valid`.
- **`full`:** asserts on the ACCUM cycle in which count reaches MAX_TRIALS; it is cleared only by `clear` or `stats_clr`.

Optional Feature:
- Macro: `AVG_ROUND_EN`.
- Defined: the divider dividend is sum + (count>>1), so avg = round-half-up(sum/count). The divider length is unchanged; dividend width grows by 1 bit if required.
- Undefined: truncating average, floor(sum/count).

Test Plan:
- **Basic stats:** reset; accept results 200, 150, 300 with gaps ≥ 20 cycles.
  - Required: last=300, min=150, max=300, avg=216 (217 with `AVG_ROUND_EN`), `trial_cnt`=3, `disp_blank`=0; check each `sel` value with 1-cycle output latency.
- **Foul and clamp:**
  - `result_valid` with `foul`=1, `result`=0 → no statistic changes, `trial_cnt` unchanged.
  - `result`=1023, `foul`=0 → stored as 999.
- **Back-to-back arrivals:**
  - Three accepted results 100, 120, 140 on cycles 0, 3, 5 → 120 is buffered, 140 is dropped, `overrun`=1.
  - Final avg=110, `trial_cnt`=2; `busy` is high for 14 cycles per divide, twice.
- **Full:** accept 15 results of 250 → `full`=1, avg=250. A 16th result of 100 → min stays 250, count stays 15, `overrun`=0.
- **Clears mid-operation:**
  - `stats_clr` during DIVIDE → next cycle `busy`=0, `disp_blank`=1, `disp_value`=0.
  - `clear` pulsed low asynchronously mid-divide → all outputs at reset values immediately.
- **Simultaneous events:** `stats_clr` and `result_valid`(200) in the same cycle → statistics empty afterwards, `trial_cnt`=0.
